// File: rtl/booth_mult_pkg.sv
// Shared types and constants for the radix-2 Booth multiplier controller.
package booth_mult_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_EVAL  = 3'd2,
    ST_ADD   = 3'd3,
    ST_SHIFT = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // Booth pair {Q[0], Q[-1]}
  localparam logic [1:0] BOOTH_NOP0 = 2'b00;
  localparam logic [1:0] BOOTH_ADD  = 2'b01;
  localparam logic [1:0] BOOTH_SUB  = 2'b10;
  localparam logic [1:0] BOOTH_NOP1 = 2'b11;

  localparam logic ADD_SUB_ADD = 1'b0;
  localparam logic ADD_SUB_SUB = 1'b1;

endpackage

// File: rtl/booth_mult_ctrl_if.sv
// Requester-side start/ready and done/ack handshake of the Booth controller.
interface booth_mult_ctrl_if;
  logic start;
  logic ack;
  logic ready;
  logic busy;
  logic done;

  modport master (output start, output ack, input ready, input busy, input done);
  modport slave  (input start, input ack, output ready, output busy, output done);
endinterface

// File: rtl/booth_iter_counter.sv
// Booth iteration counter with clear, increment and last-iteration flag.
module booth_iter_counter #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  always_ff @(posedge clk) begin
    if (!rst)     cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + CNT_W'(1);
  end

  assign last = (cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/booth_mult_ctrl.sv
// FSM sequencing a radix-2 Booth sequential multiplier datapath.
// Optional abort input enabled by defining BOOTH_MULT_ABORT_EN.
module booth_mult_ctrl
  import booth_mult_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
`ifdef BOOTH_MULT_ABORT_EN
  input  logic               abort,
`endif
  booth_mult_ctrl_if.slave   req,
  input  logic               q0,
  input  logic               q_m1,
  output logic               ld_ops,
  output logic               clr_acc,
  output logic               acc_ld,
  output logic               add_sub,
  output logic               shift_en,
  output logic [CNT_W-1:0]   iter
);

  localparam logic [2:0] S_IDLE  = ST_IDLE;
  localparam logic [2:0] S_LOAD  = ST_LOAD;
  localparam logic [2:0] S_EVAL  = ST_EVAL;
  localparam logic [2:0] S_ADD   = ST_ADD;
  localparam logic [2:0] S_SHIFT = ST_SHIFT;
  localparam logic [2:0] S_DONE  = ST_DONE;

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic       cnt_clr;
  logic       cnt_inc;
  logic       last;
  logic       in_op;
  logic       kill;

  assign in_op = (state == S_LOAD) || (state == S_EVAL) ||
                 (state == S_ADD)  || (state == S_SHIFT);

`ifdef BOOTH_MULT_ABORT_EN
  assign kill = abort && in_op;
`else
  assign kill = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      S_IDLE:  if (req.start) state_nxt = S_LOAD;
      S_LOAD: begin
        cnt_clr   = 1'b1;
        state_nxt = S_EVAL;
      end
      S_EVAL: begin
        case ({q0, q_m1})
          BOOTH_ADD, BOOTH_SUB: state_nxt = S_ADD;
          default:              state_nxt = S_SHIFT;
        endcase
      end
      S_ADD:   state_nxt = S_SHIFT;
      S_SHIFT: begin
        if (last) begin
          state_nxt = S_DONE;
        end else begin
          cnt_inc   = 1'b1;
          state_nxt = S_EVAL;
        end
      end
      S_DONE:  if (req.ack) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    // Abort wins over every in-flight transition, including the final SHIFT->DONE
    if (kill) begin
      state_nxt = S_IDLE;
      cnt_clr   = 1'b1;
      cnt_inc   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      add_sub <= ADD_SUB_ADD;
    end else if (state == S_EVAL) begin
      case ({q0, q_m1})
        BOOTH_ADD: add_sub <= ADD_SUB_ADD;
        BOOTH_SUB: add_sub <= ADD_SUB_SUB;
        default:   add_sub <= add_sub;
      endcase
    end
  end

  booth_iter_counter #(.WIDTH(WIDTH)) u_iter_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .cnt  (iter),
    .last (last)
  );

  assign req.ready = (state == S_IDLE);
  assign req.busy  = in_op;
  assign req.done  = (state == S_DONE);
  assign ld_ops    = (state == S_LOAD);
  assign clr_acc   = (state == S_LOAD);
  assign acc_ld    = (state == S_ADD);
  assign shift_en  = (state == S_SHIFT);

endmodule

// File: tb/tb_booth_mult_ctrl.sv
// Scoreboard bench for booth_mult_ctrl with a behavioural Booth datapath model.
module tb_booth_mult_ctrl;
  localparam int WIDTH = 8;
  localparam int CNT_W = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic             q0, q_m1;
  logic             ld_ops, clr_acc, acc_ld, add_sub, shift_en;
  logic [CNT_W-1:0] iter;
`ifdef BOOTH_MULT_ABORT_EN
  logic             abort = 1'b0;
`endif

  booth_mult_ctrl_if bus ();

  booth_mult_ctrl #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef BOOTH_MULT_ABORT_EN
    .abort    (abort),
`endif
    .req      (bus.slave),
    .q0       (q0),
    .q_m1     (q_m1),
    .ld_ops   (ld_ops),
    .clr_acc  (clr_acc),
    .acc_ld   (acc_ld),
    .add_sub  (add_sub),
    .shift_en (shift_en),
    .iter     (iter)
  );

  // Datapath model: M, A, Q, Q[-1]
  logic [7:0] mcand, mplier;
  logic [7:0] m_reg, a_reg, q_reg;
  logic       qm1_reg;

  always @(posedge clk) begin
    if (ld_ops) begin
      m_reg <= mcand;
      q_reg <= mplier;
    end
    if (clr_acc) begin
      a_reg   <= 8'h00;
      qm1_reg <= 1'b0;
    end
    if (acc_ld) a_reg <= add_sub ? (a_reg - m_reg) : (a_reg + m_reg);
    if (shift_en) {a_reg, q_reg, qm1_reg} <= {a_reg[7], a_reg, q_reg};
  end

  assign q0   = q_reg[0];
  assign q_m1 = qm1_reg;

  typedef struct {
    string       name;
    logic [15:0] prod;
    int          lat;
    int          nadd;
    int          nshift;
    logic [15:0] seq;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   overlap = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, expv);
  endtask

  task automatic fail_now(input string name);
    n_total++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Monitor: tallies strobes of the accepted operation and scores it at done
  bit          op_active = 1'b0;
  int          cyc, m_nadd, m_nshift;
  logic [15:0] m_seq;
  exp_t        e;

  always @(negedge clk) begin
    if (bus.done && bus.ready) overlap++;
    if (op_active) begin
      cyc++;
      if (acc_ld) begin
        m_nadd++;
        m_seq = {m_seq[14:0], add_sub};
      end
      if (shift_en) m_nshift++;
      if (bus.done) begin
        if (sb.size() == 0) begin
          fail_now("unexpected_done");
        end else begin
          e = sb.pop_front();
          chk({e.name, "_prod"},   {a_reg, q_reg}, e.prod);
          chk({e.name, "_lat"},    cyc,            e.lat);
          chk({e.name, "_nadd"},   m_nadd,         e.nadd);
          chk({e.name, "_nshift"}, m_nshift,       e.nshift);
          chk({e.name, "_seq"},    m_seq,          e.seq);
        end
        op_active = 1'b0;
      end
    end
    if (!rst) begin
      op_active = 1'b0;
`ifdef BOOTH_MULT_ABORT_EN
    end else if (abort && bus.busy) begin
      op_active = 1'b0;
`endif
    end else if (bus.ready && bus.start) begin
      op_active = 1'b1;
      cyc       = 0;
      m_nadd    = 0;
      m_nshift  = 0;
      m_seq     = '0;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string nm, input logic [7:0] mc, input logic [7:0] mp,
                        input logic [15:0] prod, input int lat, input int nadd,
                        input logic [15:0] seq, input bit poke, input bit hold);
    int k;
    k = 0;
    while (!bus.ready && k < 50) begin
      tick();
      k++;
    end
    if (!bus.ready) begin
      fail_now({nm, "_ready_wait"});
      return;
    end
    sb.push_back('{nm, prod, lat, nadd, WIDTH, seq});
    mcand     = mc;
    mplier    = mp;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    k = 0;
    while (!bus.done && k < 200) begin
      bus.start = (poke && (k == 4 || k == 9));
      tick();
      k++;
    end
    bus.start = 1'b0;
    if (!bus.done) begin
      fail_now({nm, "_done_wait"});
      return;
    end
    if (!hold) begin
      bus.ack = 1'b1;
      tick();
      bus.ack = 1'b0;
    end
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_ready"},   bus.ready, 1);
    chk({nm, "_busy"},    bus.busy,  0);
    chk({nm, "_done"},    bus.done,  0);
    chk({nm, "_iter"},    iter,      0);
    chk({nm, "_strobes"}, {ld_ops, clr_acc, acc_ld, shift_en}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bus.start = 1'b0;
    bus.ack   = 1'b0;
    mcand     = 8'h00;
    mplier    = 8'h00;
    rst       = 1'b0;
    tick();
    tick();
    chk_idle("reset");
    chk("reset_add_sub", add_sub, 0);
    rst = 1'b1;
    tick();

    // Reset in SHIFT with iter=3
    mcand = 8'h05; mplier = 8'h00;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    k = 0;
    while (!(shift_en && iter == 3'd3) && k < 100) begin
      tick();
      k++;
    end
    if (!(shift_en && iter == 3'd3)) fail_now("midreset_reach");
    rst = 1'b0;
    tick();
    chk_idle("midreset");
    rst = 1'b1;
    tick();

    run_op("zero",  8'h5A, 8'h00, 16'h0000, 18, 0, 16'h0000, 1'b0, 1'b0);
    run_op("x55",   8'h03, 8'h55, 16'h00FF, 26, 8, 16'h00AA, 1'b0, 1'b0);

    // Hold done without ack, then start+ack together
    run_op("hold",  8'h09, 8'h00, 16'h0000, 18, 0, 16'h0000, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_done",  bus.done,  1);
      chk("hold_ready", bus.ready, 0);
    end
    bus.start = 1'b1;
    bus.ack   = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.ack   = 1'b0;
    chk("startack_ready", bus.ready, 1);
    chk("startack_done",  bus.done,  0);
    chk("startack_busy",  bus.busy,  0);
    tick();
    chk("startack_noload", ld_ops,    0);
    chk("startack_idle",   bus.ready, 1);

    // Back-to-back with start pokes while busy
    run_op("m3x5",  8'hFD, 8'h05, 16'hFFF1, 22, 4, 16'h000A, 1'b1, 1'b0);
    run_op("p7xm1", 8'h07, 8'hFF, 16'hFFF9, 19, 1, 16'h0001, 1'b1, 1'b0);

`ifdef BOOTH_MULT_ABORT_EN
    mcand = 8'h07; mplier = 8'h10;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    k = 0;
    while (!(acc_ld && iter == 3'd4) && k < 100) begin
      tick();
      k++;
    end
    if (!(acc_ld && iter == 3'd4)) fail_now("abort_reach");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_idle("abort");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_nodone", bus.done, 0);
    end
    run_op("after_abort", 8'h02, 8'h03, 16'h0006, 20, 2, 16'h0002, 1'b0, 1'b0);
`endif

    tick();
    tick();
    chk("sb_empty", sb.size(), 0);
    chk("done_ready_overlap", overlap, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/booth_mult_ctrl.md
Name: booth_mult_ctrl

Overview:
- FSM controller that sequences a radix-2 Booth sequential multiplier datapath: multiplicand/multiplier registers, accumulator, add/sub unit and arithmetic shifter.
- Owns the iteration counter and the start/ready and done/ack handshakes toward the requesting logic.
- Sits between the top-level multiplier wrapper and the datapath.
- Contains no arithmetic; it only issues strobes.

Parameters:
- WIDTH, 8, operand width and number of Booth iterations; legal range 2..64.
- CNT_W, $clog2(WIDTH), iteration counter width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-low (asserted when 0, sampled on posedge clk)
- start  in  1  request a new multiplication; honoured only when ready=1
- ack  in  1  requester consumed the result; honoured only in DONE
- q0  in  1  datapath multiplier LSB
- q_m1  in  1  datapath Booth extra bit (Q[-1])
- ready  out  1  controller idle, start accepted
- busy  out  1  multiplication in progress (LOAD..SHIFT)
- ld_ops  out  1  load multiplicand and multiplier registers from operand inputs
- clr_acc  out  1  clear accumulator and Q[-1]
- acc_ld  out  1  write add/sub result into accumulator
- add_sub  out  1  0 = acc+M, 1 = acc-M; meaningful only with acc_ld
- shift_en  out  1  arithmetic right shift of {acc, Q, Q[-1]}
- done  out  1  result valid; held until ack
- iter  out  CNT_W  current iteration index (debug/observability)

Behaviour:
- States: IDLE, LOAD, EVAL, ADD, SHIFT, DONE. Strobes are Moore outputs from the state register. add_sub is registered in EVAL.
- Reset (rst=0 at posedge): state=IDLE, iter=0, add_sub=0, all strobes 0, done=0, busy=0; ready=1 from the first cycle after reset.
- IDLE: ready=1.
  - start=1 -> LOAD.
  - otherwise stay in IDLE.
- LOAD (1 cycle): ld_ops=1, clr_acc=1, iter<=0 -> EVAL.
- EVAL (1 cycle): all strobes 0; decode {q0,q_m1}.
  - 01 -> add_sub<=0, go to ADD.
  - 10 -> add_sub<=1, go to ADD.
  - 00 or 11 -> SHIFT.
- ADD (1 cycle): acc_ld=1 with the registered add_sub -> SHIFT.
- SHIFT (1 cycle): shift_en=1.
  - If iter==WIDTH-1 -> DONE.
  - Otherwise iter<=iter+1 -> EVAL.
  - iter never wraps.
- DONE: done=1, busy=0, ready=0.
  - ack=1 -> IDLE.
  - Otherwise hold; done stays asserted indefinitely.
- Latency from the start-accept edge to the first done cycle: 2 + 2*WIDTH + N_add cycles, where N_add is the number of 01/10 pairs (0..WIDTH).
- Handshake and boundary rules:
  - start outside IDLE is ignored; no queuing.
  - start and ack both high in DONE: return to IDLE only; the start is not accepted that cycle.
  - done and ready are never high together.
  - rst=0 in any state: IDLE on the next edge, no done, datapath strobes 0 that cycle.
  - q0/q_m1 are sampled only in EVAL; X on them in any other state is tolerated.

Optional Feature:
- Macro: BOOTH_MULT_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 in LOAD, EVAL, ADD or SHIFT forces IDLE on the next edge; done is not asserted and iter is cleared.
  - abort is ignored in IDLE and DONE.
  - abort has priority over the normal transition, including SHIFT->DONE on the last iteration.
- Undefined: the port does not exist; behaviour is exactly as above.

Decomposition:
- Shared package booth_mult_pkg holds:
  - the state enum typedef (3-bit encoding: IDLE=0, LOAD=1, EVAL=2, ADD=3, SHIFT=4, DONE=5);
  - Booth pair constants BOOTH_NOP0=2'b00, BOOTH_ADD=2'b01, BOOTH_SUB=2'b10, BOOTH_NOP1=2'b11;
  - ADD_SUB_ADD=0 and ADD_SUB_SUB=1.
- One sub-module, booth_iter_counter: CNT_W-bit counter with sync active-low reset, clear and increment, plus terminal flag last=(cnt==WIDTH-1).
- FSM and output decode stay in booth_mult_ctrl.

Test Plan:
- Reset mid-op: rst=0 in SHIFT with iter=3 -> next cycle state IDLE, ready=1, iter=0, every strobe 0, done=0.
- WIDTH=8, multiplier 0x00, bench datapath model supplies q0/q_m1 -> no acc_ld pulses, 8 shift_en pulses, done 18 cycles after the start edge; result 0.
- WIDTH=8, multiplier 0x55, multiplicand 0x03 -> 8 acc_ld pulses alternating add_sub=1/0, done after 26 cycles; product 0x00FF.
- Handshake: hold ack=0 for 5 cycles in DONE -> done stays 1, ready 0; then start=1 and ack=1 in the same cycle -> IDLE, start not accepted, ready=1 next cycle.
- Back-to-back: (-3)x(+5) then (+7)x(-1) with start re-asserted in the cycle after ack -> products 0xFFF1 and 0xFFF9; start pulses while busy=1 have no effect.
- With BOOTH_MULT_ABORT_EN: abort=1 in ADD at iter=4 -> IDLE next cycle, no done; a following 0x02 x 0x03 completes with product 0x0006.
